// File: rtl/fb_pixel_sink.sv
// Pixel-write sink for the 160x120 framebuffer. Incoming pixels are clipped, then queued
// in a small FIFO and drained whenever the RAM write port is granted. A clear pulse fills the whole screen.
module fb_pixel_sink #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7,
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 120,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [X_WIDTH-1:0]    x,
    input  logic [Y_WIDTH-1:0]    y,
    input  logic [7:0]            colour,
    input  logic                  writeEn,
    input  logic                  clear,
    input  logic [7:0]            clearColour,
    input  logic                  memGrant,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [7:0]            memData,
    output logic                  memWren,
    output logic                  full,
    output logic                  busy,
    output logic [7:0]            dropCount
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(X_MAX * Y_MAX - 1);

    typedef enum logic [1:0] {RUN, FLUSH, FILL} state_t;

    state_t                state, state_next;
    logic [PW:0]           count, count_next;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [7:0]            fill_colour;
    logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [7:0]            fifo_data [DEPTH];

    logic                  in_range, push, pop, reject;
    logic [ADDR_WIDTH-1:0] pix_addr;

    assign in_range = ({1'b0, x} < (X_WIDTH + 1)'(X_MAX)) && ({1'b0, y} < (Y_WIDTH + 1)'(Y_MAX));
    assign pix_addr = ADDR_WIDTH'(y) * ADDR_WIDTH'(X_MAX) + ADDR_WIDTH'(x);

    // full looks only at the current count, so a same-cycle pop never frees a slot for a push.
    assign full   = (count == (PW + 1)'(DEPTH));
    assign busy   = (count != '0) || (state != RUN);
    assign push   = writeEn && in_range && !full && (state == RUN);
    assign reject = writeEn && in_range && (full || (state != RUN));
    assign pop    = memWren && (state != FILL);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= RUN;
        else
            state <= state_next;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (clear) state_next = (count_next == '0) ? FILL : FLUSH;
            FLUSH:   if (count_next == '0) state_next = FILL;
            FILL:    if (memGrant && (fill_cnt == LAST_ADDR)) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Output logic: RAM port driven from FIFO head or fill counter
    always_comb begin
        memWren    = 1'b0;
        memAddress = fifo_addr[rd_ptr];
        memData    = fifo_data[rd_ptr];
        case (state)
            RUN, FLUSH: memWren = memGrant && (count != '0);
            FILL: begin
                memWren    = memGrant;
                memAddress = fill_cnt;
                memData    = fill_colour;
            end
            default: memWren = 1'b0;
        endcase
    end

    // NOTE: FIFO storage is reset so the idle RAM outputs read as zero straight out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= pix_addr;
                fifo_data[wr_ptr] <= colour;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_cnt    <= '0;
            fill_colour <= '0;
            dropCount   <= '0;
        end else begin
            if (state == RUN && clear)
                fill_colour <= clearColour;
            if (state != FILL && state_next == FILL)
                fill_cnt <= '0;
            else if (state == FILL && memGrant)
                fill_cnt <= (fill_cnt == LAST_ADDR) ? '0 : fill_cnt + 1'b1;
            if (reject && dropCount != 8'hFF)
                dropCount <= dropCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Scoreboard bench for fb_pixel_sink: stimulus queues expected RAM writes, a negedge
// monitor pops and compares each one the DUT issues, direct checks cover status outputs.
module tb_fb_pixel_sink;

    logic        clk;
    logic        resetn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [7:0]  colour;
    logic        writeEn;
    logic        clear;
    logic [7:0]  clearColour;
    logic        memGrant;
    logic [14:0] memAddress;
    logic [7:0]  memData;
    logic        memWren;
    logic        full;
    logic        busy;
    logic [7:0]  dropCount;

    int vectors = 0;
    int errors  = 0;
    logic [22:0] exp_q [$];

    fb_pixel_sink dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .clear(clear), .clearColour(clearColour), .memGrant(memGrant),
        .memAddress(memAddress), .memData(memData), .memWren(memWren),
        .full(full), .busy(busy), .dropCount(dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every RAM write must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && memWren) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ram_write unexpected: got addr=%0d data=%02h, none expected", memAddress, memData);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                if ({memAddress, memData} !== e) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             memAddress, memData, e[22:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int addr, input logic [7:0] data);
        exp_q.push_back({15'(addr), data});
    endtask

    task automatic set_pixel(input int px, input int py, input logic [7:0] c);
        x       = 8'(px);
        y       = 7'(py);
        colour  = c;
        writeEn = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({name, "_idle_in_budget"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; x = '0; y = '0; colour = '0; writeEn = 1'b0;
        clear = 1'b0; clearColour = '0; memGrant = 1'b1;

        // Reset state
        #3;
        check("rst_memWren", {31'b0, memWren}, 0);
        check("rst_memAddress", {17'b0, memAddress}, 0);
        check("rst_memData", {24'b0, memData}, 0);
        check("rst_full", {31'b0, full}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_dropCount", {24'b0, dropCount}, 0);
        #9 resetn = 1'b1;
        repeat (3) step();
        check("idle_memWren", {31'b0, memWren}, 0);

        // Single pixel (3,2) -> address 323, written the cycle after it is sampled
        set_pixel(3, 2, 8'hE0);
        expect_write(323, 8'hE0);
        step();
        writeEn = 1'b0;
        check("single_wren", {31'b0, memWren}, 1);
        check("single_addr", {17'b0, memAddress}, 323);
        check("single_busy", {31'b0, busy}, 1);
        step();
        check("single_busy_after", {31'b0, busy}, 0);

        // Overflow: six pixels with no grant, four stored, two dropped
        memGrant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_pixel(10 + i, 5, 8'h40 + 8'(i));
            if (i < 4) expect_write(810 + i, 8'h40 + 8'(i));
            step();
        end
        writeEn = 1'b0;
        check("ovf_full", {31'b0, full}, 1);
        check("ovf_drop", {24'b0, dropCount}, 2);
        check("ovf_no_write", {31'b0, memWren}, 0);
        memGrant = 1'b1;
        step();
        check("ovf_full_after_pop", {31'b0, full}, 0);
        wait_idle("ovf", 10);

        // Clipped pixels vanish silently
        set_pixel(160, 0, 8'hAA);   step();
        set_pixel(0, 120, 8'hBB);   step();
        set_pixel(255, 127, 8'hCC); step();
        writeEn = 1'b0;
        step();
        check("clip_drop", {24'b0, dropCount}, 2);
        check("clip_busy", {31'b0, busy}, 0);

        // Clear with two pixels queued; later clearColour changes must not leak in
        memGrant = 1'b0;
        set_pixel(0, 0, 8'h11);     expect_write(0, 8'h11);     step();
        set_pixel(159, 119, 8'h22); expect_write(19199, 8'h22); step();
        writeEn = 1'b0;
        for (int a = 0; a < 19200; a++) expect_write(a, 8'h1C);
        memGrant = 1'b1;
        clear = 1'b1;
        clearColour = 8'h1C;
        step();
        clear = 1'b0;
        clearColour = 8'hFF;
        check("clear_busy", {31'b0, busy}, 1);
        repeat (20) step();
        for (int i = 0; i < 3; i++) begin
            set_pixel(20 + i, 20, 8'h77);
            step();
        end
        writeEn = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("fill_drop", {24'b0, dropCount}, 5);
        wait_idle("fill", 20000);
        check("fill_queue_empty", exp_q.size(), 0);
        check("fill_busy_after", {31'b0, busy}, 0);
        check("fill_drop_after", {24'b0, dropCount}, 5);

        // Reset in the middle of a fill, while address 500 is being presented
        for (int a = 0; a < 500; a++) expect_write(a, 8'h5A);
        clearColour = 8'h5A;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 500; k++) begin
            writeEn = (k == 100 || k == 101);
            x = 8'd1; y = 7'd1;
            step();
        end
        writeEn = 1'b0;
        check("mid_fill_addr", {17'b0, memAddress}, 500);
        check("mid_fill_drop", {24'b0, dropCount}, 7);
        check("mid_fill_queue_done", exp_q.size(), 0);
        resetn = 1'b0;
        #1;
        check("abort_wren", {31'b0, memWren}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_drop", {24'b0, dropCount}, 0);
        check("abort_addr", {17'b0, memAddress}, 0);
        step();
        resetn = 1'b1;
        repeat (5) step();
        check("post_abort_busy", {31'b0, busy}, 0);

        // Back in RUN: a plain pixel still drains
        set_pixel(1, 1, 8'h03);
        expect_write(161, 8'h03);
        step();
        writeEn = 1'b0;
        wait_idle("post_abort", 10);
        step();
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fb_pixel_sink.md
# fb_pixel_sink

Receiving end of the pixel-write stream produced by the image draw blocks: accepts one (x, y, colour) write per cycle, clips off-screen pixels, buffers accepted pixels in a small FIFO, and drains them into the shared 160x120 framebuffer RAM whenever the scan-out arbiter grants the write port. It also performs full-screen clears with a single pulse. It sits between the game draw FSMs and the framebuffer RAM write port.

## Interface
- X_WIDTH, 8, width of x input
- Y_WIDTH, 7, width of y input
- X_MAX, 160, screen width in pixels
- Y_MAX, 120, screen height in pixels
- DEPTH, 4, FIFO entries (power of two, >= 2)
- ADDR_WIDTH, 15, framebuffer address width (must hold X_MAX*Y_MAX-1)

- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- x  in  X_WIDTH  pixel column
- y  in  Y_WIDTH  pixel row
- colour  in  8  pixel colour
- writeEn  in  1  pixel write strobe, one pixel per high cycle
- clear  in  1  request full-screen fill
- clearColour  in  8  fill colour, sampled when clear is accepted
- memGrant  in  1  RAM write port available this cycle
- memAddress  out  ADDR_WIDTH  RAM write address
- memData  out  8  RAM write data
- memWren  out  1  RAM write enable
- full  out  1  FIFO holds DEPTH entries
- busy  out  1  FIFO non-empty or clear in progress
- dropCount  out  8  saturating count of rejected in-range pixels

## Operation
- States: RUN, FLUSH, FILL.
- RUN: pixel accepted when writeEn=1, x<X_MAX, y<Y_MAX, full=0. Address y*X_MAX+x computed at enqueue, stored with colour.
- Clipped pixel (x>=X_MAX or y>=Y_MAX): discarded silently; dropCount unchanged.
- Rejected pixel: writeEn=1, in range, and (full=1 or state!=RUN) -> not stored, dropCount+1, saturates at 255.
- Drain (RUN, FLUSH): memWren = memGrant & FIFO non-empty; memAddress/memData = FIFO head; head popped at the edge where memWren=1.
- Push and pop in the same cycle: count unchanged. full is decided from current count only; a simultaneous pop does not allow a push when full=1.
- clear=1 in RUN: latch clearColour, go to FLUSH. clear in FLUSH/FILL ignored. clear and writeEn in the same RUN cycle: the pixel is still evaluated under RUN rules (accepted if room), and the clear is taken as well.
- FLUSH: keep draining; when FIFO empty, go to FILL with fill counter = 0.
- FILL: memWren = memGrant; memAddress = fill counter; memData = latched colour; counter +1 per granted cycle; after writing address X_MAX*Y_MAX-1 go to RUN.
- busy = (count!=0) | (state!=RUN).

## Timing
- Reset (async, resetn=0): state RUN, count 0, read/write pointers 0, fill counter 0, latched colour 0, dropCount 0, FIFO storage 0. Outputs: memWren 0, memAddress 0, memData 0, full 0, busy 0. Reset mid-FILL or mid-drain aborts immediately; no further RAM writes.
- Latency: pixel sampled at edge N appears as FIFO head after N; memWren can be high in cycle N+1 (with grant).
- Throughput: 1 pixel/cycle with continuous grant; FIFO never fills.
- memWren/memAddress/memData are combinational from registered state plus memGrant; the RAM samples them at the next edge.
- full/busy/dropCount are registered-derived, valid the cycle after the causing edge.
- Clear: FLUSH lasts until count=0 (0 cycles if empty, FILL entered the cycle after clear); FILL takes exactly X_MAX*Y_MAX granted cycles; busy falls the cycle after the last fill write.

## Test plan
- Reset then idle, memGrant=1: all outputs 0; memWren stays 0.
- Write (3,2,colour 0xE0) with memGrant=1 -> next cycle memWren=1, memAddress=323, memData=0xE0; busy falls after.
- memGrant=0, write 6 in-range pixels back-to-back -> first 4 stored, full=1, dropCount=2; raise memGrant -> 4 writes in order, full clears after first pop.
- Write x=160,y=0 and x=0,y=120 -> no RAM write, dropCount stays 0.
- With 2 pixels queued, pulse clear, clearColour=0x1C, memGrant=1 -> 2 pixel writes, then 19200 writes addresses 0..19199 data 0x1C; writes during FLUSH/FILL increment dropCount; busy=0 after.
- Assert resetn=0 mid-FILL at address 500 -> memWren=0 immediately, state RUN, dropCount=0, busy=0.
